// File: rtl/hazard_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hazard_pkg                                                            |
// | Shared constants for the pipeline hazard/forwarding controller.       |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package hazard_pkg;

  localparam int REG_AW_DEFAULT = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_MC  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mc_scoreboard.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mc_scoreboard                                                         |
// | Tracks the single in-flight multicycle op: countdown, destination     |
// | register and the one-cycle write-back pulse.                          |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mc_issue,
  input  logic [REG_AW-1:0] mc_dest,
  output logic [REG_AW-1:0] mc_reg,
  output logic              mc_busy,
  output logic              mc_wb_valid
);

  localparam int                 C_CNT_BITS = $clog2(MC_LAT + 1);
  localparam logic [C_CNT_BITS-1:0] C_LAT   = C_CNT_BITS'(MC_LAT);
  localparam logic [C_CNT_BITS-1:0] C_ONE   = C_CNT_BITS'(1);

  logic [C_CNT_BITS-1:0] r_mc_cnt;
  logic [REG_AW-1:0]     r_mc_reg;
  logic                  r_mc_wb_valid;

  // Pulse is registered off the 1->0 step, so issue may reuse the pulse cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mc_cnt      <= '0;
      r_mc_reg      <= '0;
      r_mc_wb_valid <= 1'b0;
    end else begin
      r_mc_wb_valid <= (r_mc_cnt == C_ONE);
      if (mc_issue && (r_mc_cnt == '0)) begin
        r_mc_cnt <= C_LAT;
        r_mc_reg <= mc_dest;
      end else if (r_mc_cnt != '0) begin
        r_mc_cnt <= r_mc_cnt - C_ONE;
      end
    end
  end

  assign mc_reg      = r_mc_reg;
  assign mc_busy     = (r_mc_cnt != '0);
  assign mc_wb_valid = r_mc_wb_valid;

`ifndef SYNTHESIS
  a_no_issue_when_busy: assert property (@(posedge clk) disable iff (!rst)
    !(mc_issue && (r_mc_cnt != '0)));
`endif

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hazard_fwd_unit                                                       |
// | Forwarding selects, load-use / multicycle / branch stalls, control    |
// | flush and saturating stall counter. HAZARD_BRANCH_FWD_EN enables MEM  |
// | forwarding into the ID branch comparator.                             |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              id_is_branch,
  input  logic              id_branch_taken,
  input  logic              id_is_jump,
  input  logic              id_is_mc,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_write_reg,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_write_reg,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic              mc_issue,
  input  logic [REG_AW-1:0] mc_dest,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              mc_busy,
  output logic              mc_wb_valid,
`ifdef HAZARD_BRANCH_FWD_EN
  output logic              fwd_id_a,
  output logic              fwd_id_b,
`endif
  output logic [CNT_W-1:0]  stall_cycles
);

  logic [REG_AW-1:0] w_mc_reg;
  logic              w_mc_busy;
  logic              w_mc_wb_valid;

  mc_scoreboard #(
    .REG_AW (REG_AW),
    .MC_LAT (MC_LAT)
  ) u_mc_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .mc_issue    (mc_issue),
    .mc_dest     (mc_dest),
    .mc_reg      (w_mc_reg),
    .mc_busy     (w_mc_busy),
    .mc_wb_valid (w_mc_wb_valid)
  );

  logic [REG_AW-1:0] w_ex_src [2];
  logic [1:0]        w_fwd    [2];

  assign w_ex_src[0] = ex_rs;
  assign w_ex_src[1] = ex_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      w_fwd[gi] = FWD_RF;
      if (w_ex_src[gi] != '0) begin
        if (mem_reg_write && (mem_write_reg == w_ex_src[gi]))
          w_fwd[gi] = FWD_MEM;
        else if (w_mc_wb_valid && (w_mc_reg == w_ex_src[gi]))
          w_fwd[gi] = FWD_MC;
        else if (wb_reg_write && (wb_write_reg == w_ex_src[gi]))
          w_fwd[gi] = FWD_WB;
      end
    end
  end

  assign forward_a = w_fwd[0];
  assign forward_b = w_fwd[1];

  // Source-read flags exclude r0, which never creates a dependence.
  logic w_rs_used, w_rt_used;
  logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
  logic w_load_use, w_mc_hazard, w_br_hazard, w_stall;

  assign w_rs_used = id_uses_rs && (id_rs != '0);
  assign w_rt_used = id_uses_rt && (id_rt != '0);
  assign w_rs_ex   = w_rs_used && (id_rs == ex_write_reg);
  assign w_rt_ex   = w_rt_used && (id_rt == ex_write_reg);
  assign w_rs_mem  = w_rs_used && (id_rs == mem_write_reg);
  assign w_rt_mem  = w_rt_used && (id_rt == mem_write_reg);

  assign w_load_use = ex_valid && ex_mem_read && ex_reg_write && (w_rs_ex || w_rt_ex);

  assign w_mc_hazard = w_mc_busy &&
                       ((w_rs_used && (id_rs == w_mc_reg)) ||
                        (w_rt_used && (id_rt == w_mc_reg)) ||
                        (id_wr_en && (id_wr_reg == w_mc_reg)) ||
                        id_is_mc);

`ifdef HAZARD_BRANCH_FWD_EN
  logic w_br_ex_alu, w_br_ex_ld, w_br_mem_ld;
  logic r_br_ld_pend;

  assign w_br_ex_alu = id_is_branch && ex_valid && ex_reg_write && !ex_mem_read &&
                       (w_rs_ex || w_rt_ex);
  assign w_br_ex_ld  = id_is_branch && ex_valid && ex_reg_write && ex_mem_read &&
                       (w_rs_ex || w_rt_ex);
  // Second stall cycle: the load has moved to MEM but its data is not ready yet.
  assign w_br_mem_ld = r_br_ld_pend && id_is_branch && mem_reg_write && (w_rs_mem || w_rt_mem);
  assign w_br_hazard = w_br_ex_alu || w_br_ex_ld || w_br_mem_ld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_br_ld_pend <= 1'b0;
    else      r_br_ld_pend <= id_valid && w_br_ex_ld;
  end

  assign fwd_id_a = id_valid && id_is_branch && mem_reg_write && w_rs_mem;
  assign fwd_id_b = id_valid && id_is_branch && mem_reg_write && w_rt_mem;
`else
  // Comparator reads the regfile only: wait until the producer reaches WB.
  assign w_br_hazard = id_is_branch &&
                       ((ex_valid && ex_reg_write && (w_rs_ex || w_rt_ex)) ||
                        (mem_reg_write && (w_rs_mem || w_rt_mem)));
`endif

  assign w_stall = id_valid && (w_load_use || w_mc_hazard || w_br_hazard);

  assign pc_write    = !w_stall;
  assign ifid_write  = !w_stall;
  assign idex_bubble = w_stall;
  assign ifid_flush  = !w_stall && id_valid &&
                       (id_is_jump || (id_is_branch && id_branch_taken));

  assign mc_busy     = w_mc_busy;
  assign mc_wb_valid = w_mc_wb_valid;

  logic [CNT_W-1:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != '1))
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
  end

  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_hazard_fwd_unit                                                    |
// | Directed + random bench for hazard_fwd_unit against a cycle-count     |
// | reference model. Rev 1.0 - initial release                            |
// +-----------------------------------------------------------------------+
module tb_hazard_fwd_unit;

  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          id_valid, id_uses_rs, id_uses_rt, id_wr_en;
  logic [AW-1:0] id_rs, id_rt, id_wr_reg;
  logic          id_is_branch, id_branch_taken, id_is_jump, id_is_mc;
  logic          ex_valid, ex_mem_read, ex_reg_write;
  logic [AW-1:0] ex_rs, ex_rt, ex_write_reg;
  logic          mem_reg_write, wb_reg_write, mc_issue;
  logic [AW-1:0] mem_write_reg, wb_write_reg, mc_dest;
  logic [1:0]    forward_a, forward_b;
  logic          pc_write, ifid_write, idex_bubble, ifid_flush, mc_busy, mc_wb_valid;
  logic [CW-1:0] stall_cycles;
`ifdef HAZARD_BRANCH_FWD_EN
  logic          fwd_id_a, fwd_id_b;
`endif

  hazard_fwd_unit #(.REG_AW(AW), .MC_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .id_is_jump(id_is_jump), .id_is_mc(id_is_mc),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .mc_issue(mc_issue), .mc_dest(mc_dest),
    .forward_a(forward_a), .forward_b(forward_b),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid),
`ifdef HAZARD_BRANCH_FWD_EN
    .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
`endif
    .stall_cycles(stall_cycles)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remembers when each multicycle op issued, in cycles.
  int            cyc      = 0;
  int            iss_cyc  = -100;
  int            old_cyc  = -100;
  logic [AW-1:0] iss_reg  = '0;
  logic [AW-1:0] old_reg  = '0;
  int            m_stalls = 0;

  function automatic bit m_busy();
    return (cyc > iss_cyc) && (cyc <= iss_cyc + LAT);
  endfunction

  function automatic bit m_wbv();
    return (cyc == iss_cyc + LAT + 1) || (cyc == old_cyc + LAT + 1);
  endfunction

  function automatic logic [AW-1:0] m_wbreg();
    return (cyc == iss_cyc + LAT + 1) ? iss_reg : old_reg;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] s);
    if (s == 0) return 2'd0;
    if (mem_reg_write && mem_write_reg == s) return 2'd2;
    if (m_wbv() && m_wbreg() == s) return 2'd3;
    if (wb_reg_write && wb_write_reg == s) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit src_hit(input logic [AW-1:0] r);
    return (r != 0) && ((id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r));
  endfunction

  function automatic bit m_stall();
    bit lu, mh, bh;
    lu = ex_valid && ex_mem_read && ex_reg_write && src_hit(ex_write_reg);
    mh = m_busy() && (src_hit(iss_reg) || (id_wr_en && id_wr_reg == iss_reg) || id_is_mc);
    bh = id_is_branch && ((ex_valid && ex_reg_write && src_hit(ex_write_reg)) ||
                          (mem_reg_write && src_hit(mem_write_reg)));
    return id_valid && (lu || mh || bh);
  endfunction

  task automatic model_reset();
    iss_cyc  = -100;
    old_cyc  = -100;
    m_stalls = 0;
  endtask

  task automatic model_update();
    if (!rst) begin
      model_reset();
    end else begin
      if (m_stall()) m_stalls = (m_stalls + 1 > SAT) ? SAT : m_stalls + 1;
      if (mc_issue && !m_busy()) begin
        old_cyc = iss_cyc;
        old_reg = iss_reg;
        iss_cyc = cyc;
        iss_reg = mc_dest;
      end
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    bit st;
    st = m_stall();
    chk("forward_a",    32'(forward_a),    32'(m_fwd(ex_rs)));
    chk("forward_b",    32'(forward_b),    32'(m_fwd(ex_rt)));
    chk("pc_write",     32'(pc_write),     32'(!st));
    chk("ifid_write",   32'(ifid_write),   32'(!st));
    chk("idex_bubble",  32'(idex_bubble),  32'(st));
    chk("ifid_flush",   32'(ifid_flush),
        32'(!st && id_valid && (id_is_jump || (id_is_branch && id_branch_taken))));
    chk("mc_busy",      32'(mc_busy),      32'(m_busy()));
    chk("mc_wb_valid",  32'(mc_wb_valid),  32'(m_wbv()));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
  endtask

  task automatic step();
    #2;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_wr_en = 0; id_wr_reg = 0; id_is_branch = 0; id_branch_taken = 0;
    id_is_jump = 0; id_is_mc = 0;
    ex_valid = 0; ex_rs = 0; ex_rt = 0; ex_mem_read = 0; ex_reg_write = 0; ex_write_reg = 0;
    mem_reg_write = 0; mem_write_reg = 0; wb_reg_write = 0; wb_write_reg = 0;
    mc_issue = 0; mc_dest = 0;
  endtask

  task automatic set_lw_ex(input logic [AW-1:0] r);
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = r;
  endtask

  initial begin
    idle();
    rst = 0;
    #12;
    chk("rst_forward_a",    32'(forward_a),    0);
    chk("rst_pc_write",     32'(pc_write),     1);
    chk("rst_ifid_write",   32'(ifid_write),   1);
    chk("rst_idex_bubble",  32'(idex_bubble),  0);
    chk("rst_mc_busy",      32'(mc_busy),      0);
    chk("rst_stall_cycles", 32'(stall_cycles), 0);
    @(negedge clk);
    rst = 1;

    // Load-use: lw r8 in EX, add r8 in ID; then lw in MEM, then WB feeding EX.
    set_lw_ex(8); id_valid = 1; id_uses_rs = 1; id_rs = 8; id_wr_en = 1; id_wr_reg = 9;
    step();
    chk("lu_stall_count", 32'(stall_cycles), 1);
    idle(); mem_reg_write = 1; mem_write_reg = 8;
    id_valid = 1; id_uses_rs = 1; id_rs = 8;
    step();
    idle(); wb_reg_write = 1; wb_write_reg = 8; ex_valid = 1; ex_rs = 8;
    step();

    // Forwarding priority and r0.
    idle(); mem_reg_write = 1; mem_write_reg = 3; wb_reg_write = 1; wb_write_reg = 3;
    ex_rs = 3; ex_rt = 3;
    step();
    idle(); mem_reg_write = 1; mem_write_reg = 0; ex_rs = 0;
    step();

    // Multicycle op to r10, dependent ID instruction stalls while busy.
    idle(); mc_issue = 1; mc_dest = 10;
    step();
    idle(); id_valid = 1; id_uses_rs = 1; id_rs = 10;
    repeat (LAT) step();
    idle(); ex_valid = 1; ex_rs = 10;
    step();
    idle(); step();

    // Back-to-back multicycle: second op waits, issues in the pulse cycle.
    idle(); mc_issue = 1; mc_dest = 11;
    step();
    idle(); id_valid = 1; id_is_mc = 1;
    repeat (LAT) step();
    mc_issue = 1; mc_dest = 12;
    step();
    idle();
    repeat (LAT + 2) step();

    // Branches: clean taken branch, then one colliding with a load-use.
    idle(); id_valid = 1; id_is_branch = 1; id_branch_taken = 1;
    id_uses_rs = 1; id_uses_rt = 1; id_rs = 1; id_rt = 2;
    step();
    set_lw_ex(5); id_rs = 5;
    step();
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_write_reg = 0;
    mem_reg_write = 1; mem_write_reg = 5;
    step();
    mem_reg_write = 0; mem_write_reg = 0; wb_reg_write = 1; wb_write_reg = 5;
    step();
    id_is_branch = 0; id_is_jump = 1;
    step();

    // Held load-use drives the counter into saturation.
    idle(); set_lw_ex(7); id_valid = 1; id_uses_rt = 1; id_rt = 7;
    repeat (SAT + 3) step();

    // Asynchronous reset with the multicycle counter at 2.
    idle(); mc_issue = 1; mc_dest = 6;
    step();
    idle();
    repeat (2) step();
    #2;
    rst = 0;
    model_reset();
    #1;
    chk("arst_mc_busy",      32'(mc_busy),      0);
    chk("arst_mc_wb_valid",  32'(mc_wb_valid),  0);
    chk("arst_stall_cycles", 32'(stall_cycles), 0);
    chk("arst_pc_write",     32'(pc_write),     1);
    @(negedge clk);
    rst = 1;
    repeat (LAT + 3) step();

    // Randomized traffic on a small register set to force collisions.
    for (int i = 0; i < 400; i++) begin
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs           = AW'($urandom_range(0, 3));
      id_rt           = AW'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom);
      id_uses_rt      = 1'($urandom);
      id_wr_en        = 1'($urandom);
      id_wr_reg       = AW'($urandom_range(0, 3));
      id_is_branch    = ($urandom_range(0, 3) == 0);
      id_branch_taken = 1'($urandom);
      id_is_jump      = ($urandom_range(0, 7) == 0);
      id_is_mc        = ($urandom_range(0, 7) == 0);
      ex_valid        = 1'($urandom);
      ex_rs           = AW'($urandom_range(0, 3));
      ex_rt           = AW'($urandom_range(0, 3));
      ex_mem_read     = 1'($urandom);
      ex_reg_write    = 1'($urandom);
      ex_write_reg    = AW'($urandom_range(0, 3));
      mem_reg_write   = 1'($urandom);
      mem_write_reg   = AW'($urandom_range(0, 3));
      wb_reg_write    = 1'($urandom);
      wb_write_reg    = AW'($urandom_range(0, 3));
      mc_issue        = !m_busy() && ($urandom_range(0, 3) == 0);
      mc_dest         = AW'($urandom_range(0, 3));
      step();
    end

    idle();
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
